// File: rtl/hps_fpga_mem_stream_reader_if.sv
// ---------------------------------------------------------------------------
// hps_fpga_mem_stream_reader_if
// Bundles the two buses of the stream reader:
//   - RAM read port: mem_address, mem_chipselect, mem_write, mem_byteenable,
//     mem_clken (driven by the reader), mem_readdata (returned by the RAM,
//     valid one clock after the address).
//   - Avalon-ST source: src_data, src_valid, src_sop, src_eop (driven by the
//     reader), src_ready (driven by the sink, readyLatency 0).
// Modports:
//   master - the reader side.
//   slave  - the RAM/sink side (testbench or surrounding fabric).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface hps_fpga_mem_stream_reader_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic                mem_clken;
  logic [DATA_W-1:0]   mem_readdata;

  logic [DATA_W-1:0]   src_data;
  logic                src_valid;
  logic                src_ready;
  logic                src_sop;
  logic                src_eop;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    input  mem_readdata,
    output src_data, src_valid, src_sop, src_eop,
    input  src_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    output mem_readdata,
    input  src_data, src_valid, src_sop, src_eop,
    output src_ready
  );
endinterface

// File: rtl/hps_fpga_mem_stream_reader.sv
// ---------------------------------------------------------------------------
// hps_fpga_mem_stream_reader
// Reads num_words consecutive 64-bit words from the on-chip RAM starting at
// base_addr and emits them as one Avalon-ST packet (sop on the first word,
// eop on the last). A small skid FIFO absorbs the one-cycle RAM read latency
// so that reads are only issued when there is guaranteed room for the data.
//
// Ports:
//   clk, reset_n   single clock, asynchronous active-low reset
//   start          launch pulse, accepted only when idle
//   base_addr      first word address (sampled on accepted start)
//   num_words      word count 0..2^ADDR_W (sampled on accepted start)
//   abort          stop the transfer and flush the FIFO (ignored when idle)
//   busy           high from accepted start until the done cycle
//   done           one-cycle completion/abort pulse
//   checksum       running XOR of accepted stream words (optional)
//   bus            RAM read port + Avalon-ST source (master modport)
//
// Build option:
//   HPS_FPGA_MEM_STREAM_READER_CHECKSUM_EN adds the checksum output and its
//   accumulator; without it neither exists.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module hps_fpga_mem_stream_reader #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic              abort,
  output logic              busy,
  output logic              done,
`ifdef HPS_FPGA_MEM_STREAM_READER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  hps_fpga_mem_stream_reader_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   rd_left;   // reads still to issue
  logic [ADDR_W:0]   out_left;  // words still to hand to the stream
  logic              sop_pend;
  logic              vld_p1;    // read issued last cycle, data on mem_readdata

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W:0]    occ;

  logic active;
  logic flush;
  logic issue;
  logic push;
  logic pop;
  logic src_vld;

  // Room check counts the word already in flight, so a read is only issued
  // when its data is certain to fit; the FIFO cannot overflow.
  always_comb begin
    active  = (state == S_RUN) || (state == S_DRAIN);
    flush   = abort && active;
    occ     = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, vld_p1};
    issue   = (state == S_RUN) && !abort && (rd_left != '0) &&
              (occ < (CNT_W+1)'(FIFO_DEPTH));
    src_vld = (fifo_cnt != '0);
    pop     = src_vld && bus.src_ready;
    push    = vld_p1 && !flush;
    cnt_nxt = fifo_cnt + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
  end

  // ---- stage p0: control FSM, read issue -------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_addr  <= '0;
      rd_left  <= '0;
      out_left <= '0;
      sop_pend <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      done   <= 1'b0;
      vld_p1 <= issue;
      if (issue) begin
        rd_addr <= rd_addr + 1'b1;  // wraps modulo 2^ADDR_W
        rd_left <= rd_left - 1'b1;
      end
      if (pop) begin
        sop_pend <= 1'b0;
        if (out_left != '0) out_left <= out_left - 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            rd_addr  <= base_addr;
            rd_left  <= num_words;
            out_left <= num_words;
            sop_pend <= 1'b1;
            if (num_words == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (issue && (rd_left == (ADDR_W+1)'(1))) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Finish in the cycle the last word leaves, so done follows it.
          if (abort || (!vld_p1 && (cnt_nxt == '0))) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---- stage p1: read data enters the skid FIFO ------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_readdata;
  end

  // ---- stage p2: stream output from the FIFO head ----------------------
  // Data is masked while invalid so the bus reads zero out of reset
  // without resetting the storage array.
  always_comb begin
    bus.src_valid      = src_vld;
    bus.src_data       = src_vld ? fifo_mem[rd_ptr] : '0;
    bus.src_sop        = src_vld && sop_pend;
    bus.src_eop        = src_vld && (out_left == (ADDR_W+1)'(1));
    bus.mem_address    = rd_addr;
    bus.mem_chipselect = issue;
    bus.mem_write      = 1'b0;
    bus.mem_byteenable = '1;
    bus.mem_clken      = 1'b1;
  end

`ifdef HPS_FPGA_MEM_STREAM_READER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (start && (state == S_IDLE)) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum ^ fifo_mem[rd_ptr];
    end
  end
`endif

endmodule

// File: doc/hps_fpga_mem_stream_reader.md
Name: hps_fpga_mem_stream_reader

Overview:
- Read sequencer directly upstream of the 64-bit single-port on-chip RAM: 13-bit word address, 8 byte enables, read data valid 1 cycle after the address.
- On a start command, reads num_words consecutive 64-bit words from base_addr.
- Emits the words as an Avalon-ST packet with backpressure, through an internal skid FIFO that absorbs the RAM read latency.
- Used to move RAM buffers filled by the HPS into FPGA streaming logic.

Parameters:
- ADDR_W, 13, RAM word address width.
- DATA_W, 64, RAM/stream data width.
- FIFO_DEPTH, 4, skid FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; launches a transfer when idle.
- base_addr  in  ADDR_W  first word address, sampled on accepted start.
- num_words  in  ADDR_W+1  words to transfer, 0..8192, sampled on accepted start.
- abort  in  1  stop transfer, flush FIFO.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion/abort pulse.
- mem_address  out  ADDR_W  RAM word address.
- mem_chipselect  out  1  RAM select; high only on read-issue cycles.
- mem_write  out  1  constant 0.
- mem_byteenable  out  DATA_W/8  constant all-ones.
- mem_clken  out  1  constant 1.
- mem_readdata  in  DATA_W  RAM read data, valid 1 cycle after issue.
- src_data  out  DATA_W  stream data (FIFO head).
- src_valid  out  1  stream valid.
- src_ready  in  1  stream ready; 0-cycle readyLatency.
- src_sop  out  1  first word of the packet.
- src_eop  out  1  last word of the packet.

Behaviour:
- Reset values: busy=0, done=0, mem_address=0, mem_chipselect=0, src_valid=0, src_sop=0, src_eop=0, src_data=0; FIFO empty; state IDLE.
- States:
  - IDLE: start with num_words>0 → RUN; latch address and remaining count; busy=1 next cycle. start with num_words=0 → DONE directly; no reads, no packet.
  - RUN: issue one read in a cycle when remaining>0 and fifo_count + inflight + 1 <= FIFO_DEPTH (inflight is 0 or 1). An issue cycle drives mem_chipselect=1, then increments the address and decrements remaining. Last issue → DRAIN.
  - DRAIN: wait until inflight=0 and FIFO empty → DONE.
  - DONE: done=1 for exactly one cycle, busy=0 from the same cycle → IDLE.
- Read data is written into the FIFO the cycle after its issue. Issue throughput is 1 word/clk while src_ready=1.
- Stream handshake:
  - A word transfers when src_valid & src_ready.
  - src_data, src_sop and src_eop stay stable while src_valid=1 and src_ready=0.
  - src_sop=1 on the first word; src_eop=1 on word num_words. A single word gets both.
- Address wrap: mem_address increments modulo 2^ADDR_W (8191 → 0). Full 8192-word transfer is legal.
- FIFO full: no issue in that cycle. FIFO never overflows, including a read still in flight.
- Simultaneous FIFO push and pop: both occur; count unchanged.
- start while busy: ignored, no effect.
- abort:
  - Has priority over all other inputs.
  - In RUN or DRAIN, the next cycle: FIFO flushed, src_valid=0, any in-flight read data discarded, state DONE.
  - In IDLE: ignored.
  - The packet may end without eop; downstream handles it.
- reset_n asserted mid-transfer: all state returns to reset values asynchronously; no done pulse.

Optional Feature:
- Macro: HPS_FPGA_MEM_STREAM_READER_CHECKSUM_EN.
- With the macro:
  - Extra output checksum, DATA_W bits: running XOR of all words accepted on the stream since the last accepted start.
  - Cleared to 0 on accepted start and on reset.
  - Holds its value after done.
- Without the macro: no checksum port and no accumulator logic.

Test Plan:
- base=0x0010, num=4, src_ready=1, RAM preloaded 0x1..0x4 → reads at 0x10..0x13 on consecutive clocks; words 1,2,3,4 out with sop on word 1, eop on word 4; done one cycle after the last transfer; busy low in that cycle.
- base=0x1FFE, num=4 → mem_address sequence 0x1FFE,0x1FFF,0x0000,0x0001; data order preserved.
- num=8, src_ready low for 10 cycles after start → exactly FIFO_DEPTH(4) reads issued, src_data holds word 0; on release all 8 words delivered in order, no loss or duplication.
- num=0 start → done pulse, zero mem_chipselect cycles, src_valid never high. start during busy → ignored, packet length unchanged.
- num=16, abort after 5 stream transfers → src_valid=0 next cycle, done pulse, busy=0; a following start base=0, num=2 gives a clean sop/eop packet.
- With checksum macro: words 0xF0,0x0F,0xFF → checksum=0x00 after done; after a new start, checksum reads 0 before the first transfer.
